// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and its control_unit consumer:
// FSM encoding, MMIO addresses and status bit positions in the receive word.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [31:0] UART_ADDR = 32'h70;
    localparam logic [31:0] LEDS_ADDR = 32'h78;

    localparam int VALID_BIT = 8;
    localparam int OVR_BIT   = 9;
    localparam int FERR_BIT  = 10;

    function automatic logic [31:0] pack_rx_word(input logic [7:0] rx_byte,
                                                 input logic valid,
                                                 input logic ovr,
                                                 input logic ferr);
        logic [31:0] w;
        w              = 32'h0;
        w[7:0]         = rx_byte;
        w[VALID_BIT]   = valid;
        w[OVR_BIT]     = ovr;
        w[FERR_BIT]    = ferr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Receiver-side MMIO/handshake bundle between the serial line, the
// receiver and control_unit.
interface uart_rx_mmio_if;
    logic        rx;
    logic        uart_read_end;
    logic [31:0] data_out;
    logic        int_sig;
    logic        busy;

    modport slave (
        input  rx,
        input  uart_read_end,
        output data_out,
        output int_sig,
        output busy
    );

    modport master (
        output rx,
        output uart_read_end,
        input  data_out,
        input  int_sig,
        input  busy
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter shared by the half-bit and full-bit intervals;
// o_tick is high while the count sits at zero.
module uart_bit_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tick
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_tick = (r_count == '0);
endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver exposing one memory-mapped receive word with sticky
// overrun/frame-error flags and a level interrupt acknowledged by uart_read_end.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 434,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_mmio_if.slave   bus
);
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_DIV - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    uart_state_t            r_state;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic [7:0]             r_byte;
    logic                   r_valid;
    logic                   r_ovr;
    logic                   r_ferr;
    logic                   r_int;
    logic                   r_int_pend;
    logic                   r_guard;

    logic                   w_rx_s;
    logic                   w_ack;
    logic                   w_tick;
    logic                   w_load;
    logic [TW-1:0]          w_load_val;

    always_ff @(posedge clk) begin
        if (rst)
            r_sync <= '1;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx};
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];
    assign w_ack  = bus.uart_read_end;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = FULL_LOAD;
        case (r_state)
            IDLE: begin
                w_load     = !r_guard && !w_rx_s;
                w_load_val = HALF_LOAD;
            end
            START, DATA: w_load = w_tick;
            default:     w_load = 1'b0;
        endcase
    end

    uart_bit_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_byte     <= 8'h00;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
            r_int      <= 1'b0;
            r_int_pend <= 1'b0;
            r_guard    <= 1'b0;
        end else begin
            if (r_int_pend) begin
                r_int      <= 1'b1;
                r_int_pend <= 1'b0;
            end
            if (w_ack) begin
                r_valid    <= 1'b0;
                r_ovr      <= 1'b0;
                r_ferr     <= 1'b0;
                r_int      <= 1'b0;
                r_int_pend <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    // after a framing error, wait for the line to go high again
                    if (r_guard) begin
                        if (w_rx_s)
                            r_guard <= 1'b0;
                    end else if (!w_rx_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7)
                            r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        if (w_rx_s) begin
                            if (r_valid && !w_ack) begin
                                r_ovr <= 1'b1;
                            end else begin
                                r_byte  <= r_shift;
                                r_valid <= 1'b1;
                                // an ack in this cycle must still produce a fresh rising edge
                                if (w_ack && r_int) begin
                                    r_int      <= 1'b0;
                                    r_int_pend <= 1'b1;
                                end else begin
                                    r_int <= 1'b1;
                                end
                            end
                        end else begin
                            r_ferr  <= 1'b1;
                            r_guard <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.data_out = pack_rx_word(r_byte, r_valid, r_ovr, r_ferr);
    assign bus.int_sig  = r_int;
    assign bus.busy     = (r_state != IDLE);
endmodule
